// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the 5-stage pipeline hazard controller.
//   - state_t   : controller state encoding (RUN / BR_SHADOW / MULTI)
//   - FWD_*     : EX operand forwarding select codes
//   - REG_PC    : architectural register number of the PC (never forwarded)
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      BR_SHADOW = 2'd1,
      MULTI     = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// ----------------------------------------------------------------------------
// hazard_fwd_unit
//   Combinational forwarding select for one EX source operand.
//   Ports:
//     src            source register of the EX instruction
//     mem_rd/mem_we  EX/MEM destination and write enable (youngest, wins)
//     wb_rd/wb_we    MEM/WB destination and write enable
//     sel            FWD_RF / FWD_EXMEM / FWD_MEMWB
// ----------------------------------------------------------------------------
module hazard_fwd_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 4
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_RF;
      // PC reads come from the fetch path, never from a pipeline result
      if (src == REG_AW'(REG_PC)) begin
         sel = FWD_RF;
      end else if (mem_we && (mem_rd == src)) begin
         sel = FWD_EXMEM;
      end else if (wb_we && (wb_rd == src)) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall / flush / forwarding controller for a 5-stage IF/ID/EX/MEM/WB core.
//   Handles load-use stalls, taken-branch flushes with a wrong-path shadow of
//   FLUSH_DEPTH cycles, and multi-cycle EX ops with a MULTI_TIMEOUT abort.
//
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     id_rn/id_rm, id_use_*      ID-stage sources and their read flags
//     ex_rn/ex_rm/ex_rd          EX-stage sources and destination
//     ex_is_load, ex_we          EX holds a load / writes ex_rd
//     ex_branch_taken            branch resolved taken in EX
//     ex_multi_start/done        multi-cycle EX op start / result valid
//     mem_rd/mem_we, wb_rd/wb_we later-stage writers for forwarding
//     pc_en, if_id_en, id_ex_en  stage-register load enables
//     if_id_flush, id_ex_flush,
//     ex_mem_bubble              NOP insertion into the stage registers
//     fwd_a_sel, fwd_b_sel       00 RF, 01 EX/MEM, 10 MEM/WB
//     multi_abort                one-cycle timeout pulse
//     hazard_err                 sticky timeout flag
//     stall_cnt, flush_cnt       performance counters
//
//   Build option: define HAZARD_PERF_EN to implement stall_cnt/flush_cnt;
//   otherwise both are tied to zero.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW        = 4,
   parameter int unsigned FLUSH_DEPTH   = 2,
   parameter int unsigned MULTI_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rn,
   input  logic [REG_AW-1:0] id_rm,
   input  logic              id_use_rn,
   input  logic              id_use_rm,
   input  logic [REG_AW-1:0] ex_rn,
   input  logic [REG_AW-1:0] ex_rm,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic              ex_we,
   input  logic              ex_branch_taken,
   input  logic              ex_multi_start,
   input  logic              ex_multi_done,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              mem_we,
   input  logic              wb_we,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              multi_abort,
   output logic              hazard_err,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);

   localparam int unsigned CNT_MAX = (FLUSH_DEPTH > MULTI_TIMEOUT) ? FLUSH_DEPTH : MULTI_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;   // shadow countdown in BR_SHADOW, cycle count in MULTI
   logic             load_use;
   logic             timeout;
   logic [1:0]       fwd_a_raw;
   logic [1:0]       fwd_b_raw;

   assign load_use = ex_is_load && ex_we &&
                     ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));

   assign timeout = (state == MULTI) && !ex_multi_done && (cnt == CNT_W'(MULTI_TIMEOUT));

   // Control outputs depend on the current-cycle hazard inputs, so they are
   // decoded combinationally from state; reset forces the safe NOP pattern.
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      multi_abort   = 1'b0;
      if (reset) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ex_multi_start) begin
                  pc_en         = 1'b0;
                  if_id_en      = 1'b0;
                  id_ex_en      = 1'b0;
                  ex_mem_bubble = 1'b1;
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            BR_SHADOW: begin
               // ID holds a wrong-path instruction, so load-use is irrelevant
               if_id_flush = 1'b1;
            end
            MULTI: begin
               if (ex_multi_done) begin
                  ex_mem_bubble = 1'b0;
               end else if (timeout) begin
                  multi_abort   = 1'b1;
                  ex_mem_bubble = 1'b1;
                  id_ex_flush   = 1'b1;
               end else begin
                  pc_en         = 1'b0;
                  if_id_en      = 1'b0;
                  id_ex_en      = 1'b0;
                  ex_mem_bubble = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         cnt        <= '0;
         hazard_err <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  if (FLUSH_DEPTH > 1) begin
                     state <= BR_SHADOW;
                     cnt   <= CNT_W'(FLUSH_DEPTH - 1);
                  end
               end else if (ex_multi_start) begin
                  state <= MULTI;
                  cnt   <= CNT_W'(1);
               end
            end
            BR_SHADOW: begin
               if (cnt <= CNT_W'(1)) begin
                  state <= RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            MULTI: begin
               if (ex_multi_done) begin
                  state <= RUN;
                  cnt   <= '0;
               end else if (timeout) begin
                  state      <= RUN;
                  cnt        <= '0;
                  hazard_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .src    (ex_rn),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd_a_raw)
   );

   hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .src    (ex_rm),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd_b_raw)
   );

   assign fwd_a_sel = reset ? FWD_RF : fwd_a_raw;
   assign fwd_b_sel = reset ? FWD_RF : fwd_b_raw;

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
         end
         if ((state == RUN) && ex_branch_taken && (flush_q != '1)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl (default parameters:
//   FLUSH_DEPTH=2, MULTI_TIMEOUT=16). Control outputs are checked as the
//   packed vector {pc_en,if_id_en,id_ex_en,if_id_flush,id_ex_flush,ex_mem_bubble}.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam logic [5:0] C_RESET  = 6'b000111;
   localparam logic [5:0] C_RUN    = 6'b111000;
   localparam logic [5:0] C_LDUSE  = 6'b001010;
   localparam logic [5:0] C_BRANCH = 6'b111110;
   localparam logic [5:0] C_SHADOW = 6'b111100;
   localparam logic [5:0] C_MULTI  = 6'b000001;
   localparam logic [5:0] C_ABORT  = 6'b111011;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
   logic       id_use_rn, id_use_rm, ex_is_load, ex_we;
   logic       ex_branch_taken, ex_multi_start, ex_multi_done;
   logic       mem_we, wb_we;
   logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       multi_abort, hazard_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic [5:0] ctl;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   assign ctl = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .id_rn           (id_rn),
      .id_rm           (id_rm),
      .id_use_rn       (id_use_rn),
      .id_use_rm       (id_use_rm),
      .ex_rn           (ex_rn),
      .ex_rm           (ex_rm),
      .ex_rd           (ex_rd),
      .ex_is_load      (ex_is_load),
      .ex_we           (ex_we),
      .ex_branch_taken (ex_branch_taken),
      .ex_multi_start  (ex_multi_start),
      .ex_multi_done   (ex_multi_done),
      .mem_rd          (mem_rd),
      .wb_rd           (wb_rd),
      .mem_we          (mem_we),
      .wb_we           (wb_we),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_bubble   (ex_mem_bubble),
      .fwd_a_sel       (fwd_a_sel),
      .fwd_b_sel       (fwd_b_sel),
      .multi_abort     (multi_abort),
      .hazard_err      (hazard_err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counter expectations only apply when the performance option is built in
   task automatic chk_perf(input string tag, input logic [15:0] exp_stall, input logic [15:0] exp_flush);
`ifdef HAZARD_PERF_EN
      chk({tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, exp_stall});
      chk({tag, "_flush"}, {16'd0, flush_cnt}, {16'd0, exp_flush});
`else
      chk({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
      chk({tag, "_flush"}, {16'd0, flush_cnt}, 32'd0);
      if (exp_stall == 16'hFFFF || exp_flush == 16'hFFFF) n_cmp = n_cmp;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl_inputs();
      id_rn = '0; id_rm = '0; id_use_rn = 1'b0; id_use_rm = 1'b0;
      ex_rd = '0; ex_is_load = 1'b0; ex_we = 1'b0;
      ex_branch_taken = 1'b0; ex_multi_start = 1'b0; ex_multi_done = 1'b0;
   endtask

   task automatic clear_fwd_inputs();
      ex_rn = '0; ex_rm = '0; mem_rd = '0; wb_rd = '0; mem_we = 1'b0; wb_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_ctl_inputs();
      clear_fwd_inputs();

      // ---------------- reset state ----------------
      #2;
      chk("rst_ctl",   {26'd0, ctl}, {26'd0, C_RESET});
      chk("rst_fwd",   {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
      chk("rst_abort", {31'd0, multi_abort}, 32'd0);
      chk("rst_err",   {31'd0, hazard_err}, 32'd0);
      chk_perf("rst", 16'd0, 16'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("run_idle", {26'd0, ctl}, {26'd0, C_RUN});

      // ---------------- load-use via rn ----------------
      ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1'b1;
      #1;
      chk("lu_rn", {26'd0, ctl}, {26'd0, C_LDUSE});
      tick();
      clear_ctl_inputs();
      #1;
      chk("lu_rn_after", {26'd0, ctl}, {26'd0, C_RUN});

      // matching register but not read: no stall
      ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1'b0;
      #1;
      chk("lu_not_used", {26'd0, ctl}, {26'd0, C_RUN});
      // load without writeback: no stall
      id_use_rn = 1'b1; ex_we = 1'b0;
      #1;
      chk("lu_no_we", {26'd0, ctl}, {26'd0, C_RUN});
      // non-load producer: forwarding handles it, no stall
      ex_we = 1'b1; ex_is_load = 1'b0;
      #1;
      chk("lu_not_load", {26'd0, ctl}, {26'd0, C_RUN});
      tick();

      // load-use via rm
      clear_ctl_inputs();
      ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd9; id_rm = 4'd9; id_use_rm = 1'b1; id_rn = 4'd1; id_use_rn = 1'b1;
      #1;
      chk("lu_rm", {26'd0, ctl}, {26'd0, C_LDUSE});
      tick();
      clear_ctl_inputs();
      #1;
      chk_perf("after_lu", 16'd2, 16'd0);

      // ---------------- taken branch (beats a simultaneous load-use) ----------------
      ex_branch_taken = 1'b1;
      ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd5; id_rn = 4'd5; id_use_rn = 1'b1;
      #1;
      chk("br_cyc0", {26'd0, ctl}, {26'd0, C_BRANCH});
      tick();
      ex_branch_taken = 1'b0;
      #1;
      chk("br_shadow_ignores_lu", {26'd0, ctl}, {26'd0, C_SHADOW});
      tick();
      clear_ctl_inputs();
      #1;
      chk("br_back_run", {26'd0, ctl}, {26'd0, C_RUN});
      chk_perf("after_br", 16'd2, 16'd1);

      // ---------------- multi-cycle op, done after 5 cycles ----------------
      // done on the start cycle must be ignored; branch beats... only start here
      ex_multi_start = 1'b1; ex_multi_done = 1'b1;
      #1;
      chk("mc_start", {26'd0, ctl}, {26'd0, C_MULTI});
      tick();
      ex_multi_start = 1'b0; ex_multi_done = 1'b0;
      ex_branch_taken = 1'b1;   // ignored while MULTI holds EX
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk("mc_hold", {26'd0, ctl}, {26'd0, C_MULTI});
         tick();
      end
      ex_branch_taken = 1'b0;
      ex_multi_done = 1'b1;
      #1;
      chk("mc_done", {26'd0, ctl}, {26'd0, C_RUN});
      tick();
      ex_multi_done = 1'b0;
      #1;
      chk("mc_after", {26'd0, ctl}, {26'd0, C_RUN});
      chk_perf("after_mc", 16'd7, 16'd1);

      // ---------------- multi-cycle timeout ----------------
      ex_multi_start = 1'b1;
      #1;
      chk("to_start", {26'd0, ctl}, {26'd0, C_MULTI});
      tick();
      ex_multi_start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         #1;
         chk("to_hold", {26'd0, ctl}, {26'd0, C_MULTI});
         chk("to_hold_abort", {31'd0, multi_abort}, 32'd0);
         tick();
      end
      #1;
      chk("to_abort_ctl", {26'd0, ctl}, {26'd0, C_ABORT});
      chk("to_abort_pulse", {31'd0, multi_abort}, 32'd1);
      chk("to_err_before", {31'd0, hazard_err}, 32'd0);
      tick();
      #1;
      chk("to_after_ctl", {26'd0, ctl}, {26'd0, C_RUN});
      chk("to_after_pulse", {31'd0, multi_abort}, 32'd0);
      chk("to_err_set", {31'd0, hazard_err}, 32'd1);
      tick();
      tick();
      chk("to_err_sticky", {31'd0, hazard_err}, 32'd1);
      chk_perf("after_to", 16'd23, 16'd1);

      // ---------------- forwarding ----------------
      ex_rn = 4'd2; mem_we = 1'b1; mem_rd = 4'd2; wb_we = 1'b1; wb_rd = 4'd2;
      #1;
      chk("fwd_a_exmem_prio", {30'd0, fwd_a_sel}, 32'd1);
      mem_we = 1'b0;
      #1;
      chk("fwd_a_memwb", {30'd0, fwd_a_sel}, 32'd2);
      wb_we = 1'b0;
      #1;
      chk("fwd_a_rf", {30'd0, fwd_a_sel}, 32'd0);
      ex_rm = 4'd15; wb_we = 1'b1; wb_rd = 4'd15; mem_we = 1'b1; mem_rd = 4'd15;
      #1;
      chk("fwd_b_pc", {30'd0, fwd_b_sel}, 32'd0);
      ex_rm = 4'd7; mem_rd = 4'd6; wb_rd = 4'd7;
      #1;
      chk("fwd_b_memwb", {30'd0, fwd_b_sel}, 32'd2);
      chk("fwd_a_nomatch", {30'd0, fwd_a_sel}, 32'd0);

      // ---------------- async reset mid-MULTI ----------------
      clear_fwd_inputs();
      ex_rn = 4'd2; mem_we = 1'b1; mem_rd = 4'd2;
      tick();
      ex_multi_start = 1'b1;
      tick();
      ex_multi_start = 1'b0;
      tick();
      #2;
      chk("rm_in_multi", {26'd0, ctl}, {26'd0, C_MULTI});
      reset = 1'b1;
      #1;
      chk("rm_rst_ctl", {26'd0, ctl}, {26'd0, C_RESET});
      chk("rm_rst_fwd", {30'd0, fwd_a_sel}, 32'd0);
      chk("rm_rst_err", {31'd0, hazard_err}, 32'd0);
      chk_perf("rm_rst", 16'd0, 16'd0);
      reset = 1'b0;
      #1;
      chk("rm_release_ctl", {26'd0, ctl}, {26'd0, C_RUN});
      chk("rm_release_fwd", {30'd0, fwd_a_sel}, 32'd1);
      tick();
      chk("rm_stays_run", {26'd0, ctl}, {26'd0, C_RUN});

      // ---------------- async reset mid-BR_SHADOW ----------------
      ex_branch_taken = 1'b1;
      tick();
      ex_branch_taken = 1'b0;
      #1;
      chk("rs_in_shadow", {26'd0, ctl}, {26'd0, C_SHADOW});
      reset = 1'b1;
      #1;
      chk("rs_rst_ctl", {26'd0, ctl}, {26'd0, C_RESET});
      chk_perf("rs_rst", 16'd0, 16'd0);
      reset = 1'b0;
      #1;
      chk("rs_release_ctl", {26'd0, ctl}, {26'd0, C_RUN});
      tick();
      chk("rs_stays_run", {26'd0, ctl}, {26'd0, C_RUN});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage ARM-style CPU (IF/ID/EX/MEM/WB).
- Sequences stage-register enables and flushes for:
  - load-use stalls
  - taken-branch flushes, including a multi-cycle wrong-path shadow
  - multi-cycle EX operations, with timeout
- Also generates EX operand forwarding selects.
- Sits beside the datapath; drives the pipeline-register enable and flush pins.

Parameters:
- REG_AW, 4, register-address width (R0..R15).
- FLUSH_DEPTH, 2, total cycles of IF/ID flush after a taken branch (≥1).
- MULTI_TIMEOUT, 16, maximum cycles a multi-cycle EX op may hold EX before abort.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rn, id_rm  in  REG_AW  source registers of the instruction in ID.
- id_use_rn, id_use_rm  in  1  source actually read.
- ex_rn, ex_rm  in  REG_AW  sources of the instruction in EX (forwarding).
- ex_rd  in  REG_AW  destination in EX.
- ex_is_load  in  1  EX holds a load.
- ex_we  in  1  EX writes ex_rd.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_multi_start  in  1  multi-cycle op entering execution.
- ex_multi_done  in  1  multi-cycle result valid.
- mem_rd, wb_rd  in  REG_AW  MEM/WB destinations.
- mem_we, wb_we  in  1  MEM/WB write enables.
- pc_en, if_id_en, id_ex_en  out  1  stage-register load enables.
- if_id_flush, id_ex_flush, ex_mem_bubble  out  1  insert NOP into that register.
- fwd_a_sel, fwd_b_sel  out  2  00 register file, 01 EX/MEM, 10 MEM/WB.
- multi_abort  out  1  single-cycle timeout pulse.
- hazard_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  16  performance counters (see Optional Feature).

Behaviour:
- Reset (asynchronous, held):
  - state=RUN, counters=0, hazard_err=0, multi_abort=0.
  - While reset is high: all enables=0, all flush/bubble=1, fwd=00.
- States: RUN, BR_SHADOW, MULTI.
- Priority within one cycle: ex_branch_taken > ex_multi_start > load-use.
- RUN:
  - Default: all enables=1, all flushes=0.
  - Taken branch:
    - Outputs: if_id_flush=1, id_ex_flush=1, pc_en=1 (target loads).
    - If FLUSH_DEPTH>1, go to BR_SHADOW with shadow counter=FLUSH_DEPTH-1.
  - ex_multi_start:
    - Outputs: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1.
    - Go to MULTI with cycle counter=1.
  - Load-use (ex_is_load & ex_we & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd))):
    - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1.
    - Exactly one bubble; state stays RUN.
- BR_SHADOW:
  - Outputs: if_id_flush=1, id_ex_flush=0, enables=1.
  - Counter decrements; return to RUN when it reaches 1.
  - A load-use hazard is ignored here, because the ID instruction is being flushed.
- MULTI:
  - Outputs: upstream enables=0, ex_mem_bubble=1 until ex_multi_done.
  - On the done cycle: ex_mem_bubble=0, enables=1, go to RUN.
  - Done on the start cycle is illegal; it is ignored.
  - Counter==MULTI_TIMEOUT without done:
    - multi_abort=1 for one cycle, hazard_err set.
    - ex_mem_bubble=1, id_ex_flush=1, enables=1, go to RUN.
  - ex_branch_taken is ignored in MULTI.
- Forwarding, per operand, combinational:
  - Select 01 if mem_we & mem_rd==src.
  - Else select 10 if wb_we & wb_rd==src.
  - Else select 00.
  - src==4'd15 (PC) always selects 00.
- Reset asserted mid-MULTI or mid-BR_SHADOW: immediate return to RUN; counters cleared.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with pc_en=0 outside reset.
  - flush_cnt increments once per taken branch accepted in RUN.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: stall_cnt and flush_cnt are constant 0; no counter flops.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state encoding (RUN=2'd0, BR_SHADOW=2'd1, MULTI=2'd2)
  - FWD_RF/FWD_EXMEM/FWD_MEMWB constants
  - REG_PC=4'd15
- Sub-module hazard_fwd_unit: combinational forwarding-select logic, instantiated twice (operand A, operand B).

Test Plan:
- Load-use: ex_is_load=1, ex_rd=3, ex_we=1, id_rn=3, id_use_rn=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1.
- Branch with FLUSH_DEPTH=2: ex_branch_taken pulse -> cycle 0 if_id_flush=id_ex_flush=1, pc_en=1; cycle 1 if_id_flush=1 only; cycle 2 RUN; flush_cnt=1 with HAZARD_PERF_EN.
- Multi-cycle: ex_multi_start, done after 5 cycles -> pc_en=0 for 5 cycles, ex_mem_bubble=0 on the done cycle, stall_cnt=5.
- Timeout: ex_multi_start, no done -> multi_abort pulses at cycle 16, hazard_err stays 1 until reset.
- Forwarding: mem_we=1, mem_rd=2, wb_we=1, wb_rd=2, ex_rn=2 -> fwd_a_sel=01; ex_rm=15 with wb_rd=15 -> fwd_b_sel=00.
- Reset asserted asynchronously mid-MULTI -> outputs take reset values immediately; after deassert state=RUN, enables=1.
